multicycle_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the single-issue processor. It owns the PC and the per-instruction state register and steps each instruction through FETCH, DECODE, RF_READ, EXECUTE, MEM and WB.
- Adds stalling request/acknowledge handshakes to instruction and data memory, with a timeout on each.
- Applies branch/jump redirect at WB.
- Terminates on halt, invalid instruction or program end, and counts retired instructions.
- Drives the state bus consumed by fetch, decode, register file and execute.

---
 rtl/multicycle_sequencer_pkg.sv | 16 +
 rtl/multicycle_sequencer_handshake_timer.sv | 25 ++
 rtl/multicycle_sequencer.sv | 159 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared state encoding for the multi-cycle instruction sequencer.
package multicycle_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_RF_READ = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

endpackage

// File: rtl/multicycle_sequencer_handshake_timer.sv
// Ack wait counter shared by the FETCH and MEM handshakes; flags the last allowed cycle.
module multicycle_sequencer_handshake_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + CW'(1);
    end

    // High on the cycle whose missing ack would bring the count to WAIT_MAX.
    assign timeout = enable && (cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: owns the PC, steps each instruction through
// FETCH..WB, handles memory handshakes with timeout, redirects and termination.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_FETCH   | imem_req high, waiting for imem_ack (timed)
// S_DECODE  | instruction decode, one cycle
// S_RF_READ | register file read, one cycle
// S_EXECUTE | execute; control fields latched, halt/invalid resolved
// S_MEM     | data access (timed on dmem_ack) or single bubble cycle
// S_WB      | retire, compute next PC, detect program end / bad target
// S_HALT    | absorbing; done high, error held until reset
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int PROG_LEN = 256,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16,
    parameter int SKIP_MEM = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    input  logic               is_mem,
    input  logic               is_jump,
    input  logic               branch_taken,
    input  logic [15:0]        branch_offset,
    input  logic [25:0]        jump_target,
    input  logic               is_halt,
    input  logic               instruction_invalid,
    output logic [PC_W-1:0]    pc,
    output logic [STATE_W-1:0] state,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               done,
    output logic               error,
    output logic [CNT_W-1:0]   retired
);

    state_t          state_q;
    logic            mem_l;
    logic            jump_l;
    logic            br_l;
    logic [15:0]     off_l;
    logic [PC_W-1:0] tgt_l;

    logic            wait_en;
    logic            timeout;
    logic [PC_W-1:0] next_pc;
    logic            redirect;
    logic            redirect_bad;
    logic            seq_end;
    logic            unused_tgt_bits;

    assign unused_tgt_bits = ^jump_target;

    assign wait_en = ((state_q == S_FETCH) && !imem_ack) ||
                     ((state_q == S_MEM) && mem_l && !dmem_ack);

    multicycle_sequencer_handshake_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clk     (clk),
        .clear   (reset || !wait_en),
        .enable  (wait_en),
        .timeout (timeout)
    );

    // Branch target wraps modulo 2^PC_W; jump takes priority over branch.
    always_comb begin
        next_pc = pc + PC_W'(1);
        if (jump_l)
            next_pc = tgt_l;
        else if (br_l)
            next_pc = PC_W'(32'(pc) + 32'd1 + {{16{off_l[15]}}, off_l});
    end

    assign redirect     = jump_l || br_l;
    assign redirect_bad = 33'(next_pc) >= 33'(PROG_LEN);
    // Computed one bit wider so the wrap case with PROG_LEN == 2^PC_W also ends the program.
    assign seq_end      = (33'(pc) + 33'd1) >= 33'(PROG_LEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc      <= '0;
            error   <= 1'b0;
            retired <= '0;
            mem_l   <= 1'b0;
            jump_l  <= 1'b0;
            br_l    <= 1'b0;
            off_l   <= '0;
            tgt_l   <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack)
                        state_q <= S_DECODE;
                    else if (timeout) begin
                        state_q <= S_HALT;
                        error   <= 1'b1;
                    end
                end
                S_DECODE:  state_q <= S_RF_READ;
                S_RF_READ: state_q <= S_EXECUTE;
                S_EXECUTE: begin
                    mem_l  <= is_mem;
                    jump_l <= is_jump;
                    br_l   <= branch_taken;
                    off_l  <= branch_offset;
                    tgt_l  <= jump_target[PC_W-1:0];
                    if (is_halt)
                        state_q <= S_HALT;
                    else if (instruction_invalid) begin
                        state_q <= S_HALT;
                        error   <= 1'b1;
                    end else if (is_mem || (SKIP_MEM == 0))
                        state_q <= S_MEM;
                    else
                        state_q <= S_WB;
                end
                S_MEM: begin
                    if (!mem_l || dmem_ack)
                        state_q <= S_WB;
                    else if (timeout) begin
                        state_q <= S_HALT;
                        error   <= 1'b1;
                    end
                end
                S_WB: begin
                    if (retired != {CNT_W{1'b1}})
                        retired <= retired + CNT_W'(1);
                    if (redirect && redirect_bad) begin
                        state_q <= S_HALT;
                        error   <= 1'b1;
                    end else if (!redirect && seq_end)
                        state_q <= S_HALT;
                    else begin
                        pc      <= next_pc;
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: begin
                    state_q <= S_HALT;
                    error   <= 1'b1;
                end
            endcase
        end
    end

    assign state    = state_q;
    assign imem_req = (state_q == S_FETCH);
    assign dmem_req = (state_q == S_MEM) && mem_l;
    assign done     = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: a default-size sequencer plus an 8-entry program variant share stimulus.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack, dmem_ack, is_mem, is_jump, branch_taken, is_halt, instruction_invalid;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;

    logic [7:0]  pc, s_pc;
    logic [2:0]  state, s_state;
    logic        imem_req, dmem_req, done, error;
    logic        s_imem_req, s_dmem_req, s_done, s_error;
    logic [15:0] retired, s_retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .PC_W(8), .PROG_LEN(256), .WAIT_MAX(15), .CNT_W(16), .SKIP_MEM(1)
    ) u_dut (
        .clk(clk), .reset(reset), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .is_mem(is_mem), .is_jump(is_jump), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump_target(jump_target), .is_halt(is_halt),
        .instruction_invalid(instruction_invalid), .pc(pc), .state(state),
        .imem_req(imem_req), .dmem_req(dmem_req), .done(done), .error(error),
        .retired(retired)
    );

    multicycle_sequencer #(
        .PC_W(8), .PROG_LEN(8), .WAIT_MAX(15), .CNT_W(16), .SKIP_MEM(1)
    ) u_small (
        .clk(clk), .reset(reset), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .is_mem(is_mem), .is_jump(is_jump), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump_target(jump_target), .is_halt(is_halt),
        .instruction_invalid(instruction_invalid), .pc(s_pc), .state(s_state),
        .imem_req(s_imem_req), .dmem_req(s_dmem_req), .done(s_done), .error(s_error),
        .retired(s_retired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alu();
        is_mem = 0; is_jump = 0; branch_taken = 0; branch_offset = '0;
        jump_target = '0; is_halt = 0; instruction_invalid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cyc(1);
        reset = 0;
    endtask

    initial begin
        reset = 1; imem_ack = 0; dmem_ack = 0;
        alu();
        cyc(2);
        reset = 0;

        check("rst_state", state, 0);
        check("rst_pc", pc, 0);
        check("rst_imem_req", imem_req, 1);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_retired", retired, 0);

        // Straight-line ALU code, five cycles per instruction
        imem_ack = 1;
        cyc(4);
        check("alu_in_wb", state, 5);
        cyc(11);
        check("alu3_pc", pc, 3);
        check("alu3_retired", retired, 3);
        check("alu3_state", state, 0);

        // Load at pc=4 with dmem_ack three cycles late
        cyc(5);
        check("pre_load_pc", pc, 4);
        is_mem = 1;
        cyc(4);
        check("load_mem_state", state, 4);
        check("load_dmem_req", dmem_req, 1);
        cyc(3);
        check("load_still_mem", state, 4);
        dmem_ack = 1;
        cyc(1);
        check("load_wb_state", state, 5);
        check("load_wb_dmem_req", dmem_req, 0);
        dmem_ack = 0;
        alu();
        cyc(1);
        check("load_pc", pc, 5);
        check("load_retired", retired, 5);

        // Backward branch from pc=10 then jump beating branch
        cyc(25);
        check("pre_br_pc", pc, 10);
        branch_taken = 1; branch_offset = 16'hFFFA;
        cyc(5);
        check("br_pc", pc, 5);
        check("br_retired", retired, 11);
        is_jump = 1; jump_target = 26'd40;
        cyc(5);
        check("jmp_pc", pc, 40);
        check("jmp_retired", retired, 12);
        alu();

        // Instruction fetch timeout
        imem_ack = 0;
        cyc(14);
        check("ito_still_fetch", state, 0);
        check("ito_imem_req", imem_req, 1);
        cyc(1);
        check("ito_state", state, 6);
        check("ito_done", done, 1);
        check("ito_error", error, 1);
        check("ito_pc", pc, 40);
        check("ito_imem_req_off", imem_req, 0);
        imem_ack = 1;
        cyc(6);
        check("halt_absorb", state, 6);
        check("halt_retired", retired, 12);

        // Program end on the 8-entry variant
        do_reset();
        cyc(39);
        check("end_small_wb", s_state, 5);
        cyc(1);
        check("end_small_done", s_done, 1);
        check("end_small_error", s_error, 0);
        check("end_small_retired", s_retired, 8);
        check("end_small_pc", s_pc, 7);
        check("end_big_pc", pc, 8);

        // Jump beyond the 8-entry program
        do_reset();
        is_jump = 1; jump_target = 26'd9;
        cyc(5);
        check("badjmp_done", s_done, 1);
        check("badjmp_error", s_error, 1);
        check("badjmp_pc", s_pc, 0);
        check("badjmp_big_pc", pc, 9);
        check("badjmp_big_done", done, 0);
        alu();

        // Branch wrapping below zero, then sequential wrap ends the program
        do_reset();
        branch_taken = 1; branch_offset = 16'hFFFE;
        cyc(5);
        check("wrap_br_pc", pc, 255);
        check("wrap_br_done", done, 0);
        check("wrap_small_error", s_error, 1);
        alu();
        cyc(5);
        check("wrap_end_done", done, 1);
        check("wrap_end_error", error, 0);
        check("wrap_end_pc", pc, 255);
        check("wrap_end_retired", retired, 2);

        // Halt instruction does not retire
        do_reset();
        cyc(5);
        is_halt = 1;
        cyc(4);
        check("halt_state", state, 6);
        check("halt_error", error, 0);
        check("halt_no_retire", retired, 1);
        check("halt_pc", pc, 1);

        // Invalid instruction, and halt taking priority over invalid
        do_reset();
        is_halt = 0; instruction_invalid = 1;
        cyc(4);
        check("inval_done", done, 1);
        check("inval_error", error, 1);
        check("inval_retired", retired, 0);
        do_reset();
        is_halt = 1;
        cyc(4);
        check("halt_over_inval_done", done, 1);
        check("halt_over_inval_error", error, 0);
        alu();

        // Data access timeout
        do_reset();
        is_mem = 1; dmem_ack = 0;
        cyc(4);
        check("dto_in_mem", state, 4);
        cyc(14);
        check("dto_still_mem", state, 4);
        cyc(1);
        check("dto_state", state, 6);
        check("dto_error", error, 1);
        check("dto_retired", retired, 0);

        // Reset in MEM coincident with dmem_ack
        do_reset();
        alu();
        cyc(5);
        is_mem = 1;
        cyc(4);
        check("rstmem_pre_state", state, 4);
        check("rstmem_pre_retired", retired, 1);
        reset = 1; dmem_ack = 1;
        cyc(1);
        reset = 0; dmem_ack = 0;
        check("rstmem_state", state, 0);
        check("rstmem_pc", pc, 0);
        check("rstmem_retired", retired, 0);
        check("rstmem_done", done, 0);
        check("rstmem_imem_req", imem_req, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
